// File: rtl/accum_bank_if.sv
// Bank port bundle for accum_bank: upstream write strobe, drain control and
// the downstream valid/ready drain stream.
interface accum_bank_if #(
  parameter int DEPTH     = 64,
  parameter int ROW_WIDTH = 8
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [1:0]           bitwidth;
  logic                 wr_en;
  logic [ROW_WIDTH-1:0] wr_row;
  logic [7:0]           wr_data;
  logic                 busy;
  logic                 drain_start;
  logic                 out_valid;
  logic                 out_ready;
  logic [IDX_W-1:0]     out_entry;
  logic [7:0]           out_data;
  logic                 drain_done;
  logic                 sat_flag;

  modport master (
    output bitwidth, wr_en, wr_row, wr_data, drain_start, out_ready,
    input  busy, out_valid, out_entry, out_data, drain_done, sat_flag
  );

  modport slave (
    input  bitwidth, wr_en, wr_row, wr_data, drain_start, out_ready,
    output busy, out_valid, out_entry, out_data, drain_done, sat_flag
  );
endinterface

// File: rtl/accum_bank.sv
// Saturating 8-bit accumulator bank: 2-stage read-modify-write with
// forwarding, and a flush/drain sequencer that streams out and clears entries.
module accum_bank #(
  parameter int DEPTH     = 64,
  parameter int ROW_WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  accum_bank_if.slave  bus,
  output logic [1:0]   dbg_state_o
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             flush_cnt_q, flush_cnt_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             drain_done_q, drain_done_d;
  logic             sat_q;

  logic signed [7:0] mem_q [DEPTH];

  logic              s1_vld_q;
  logic [IDX_W-1:0]  s1_idx_q;
  logic signed [7:0] s1_data_q;
  logic signed [7:0] s1_base_q;

  logic              wr_acc;
  logic [IDX_W-1:0]  wr_idx;
  logic signed [7:0] base_sel;
  logic signed [8:0] sum_wide;
  logic              sum_ovf;
  logic signed [7:0] sum_sat;
  logic              accept;

  // Writes are only taken in IDLE; a write in the drain_start cycle still lands.
  assign wr_acc = bus.wr_en && (state_q == IDLE);
  assign wr_idx = IDX_W'(bus.wr_row >> bus.bitwidth);

  // Stage 2 of the same entry has not written back yet, so take its result.
  assign base_sel = (s1_vld_q && (s1_idx_q == wr_idx)) ? sum_sat : mem_q[wr_idx];

  assign sum_wide = {s1_base_q[7], s1_base_q} + {s1_data_q[7], s1_data_q};
  assign sum_ovf  = (sum_wide[8] != sum_wide[7]);
  assign sum_sat  = !sum_ovf    ? sum_wide[7:0] :
                    sum_wide[8] ? 8'sh80 : 8'sh7f;

  // Drain stream: an entry transfers on any cycle with out_valid && out_ready;
  // while out_ready is low, out_entry/out_data stay put.
  assign accept = (state_q == DRAIN) && bus.out_ready;

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    cnt_d        = cnt_q;
    drain_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.drain_start) begin
          state_d     = FLUSH;
          flush_cnt_d = 1'b0;
        end
      end
      FLUSH: begin
        if (flush_cnt_q) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          flush_cnt_d = 1'b1;
        end
      end
      DRAIN: begin
        if (accept) begin
          if (cnt_q == IDX_W'(DEPTH - 1)) begin
            state_d      = IDLE;
            drain_done_d = 1'b1;
            cnt_d        = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      flush_cnt_q  <= 1'b0;
      cnt_q        <= '0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      cnt_q        <= cnt_d;
      drain_done_q <= drain_done_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_q  <= 1'b0;
      s1_idx_q  <= '0;
      s1_data_q <= '0;
      s1_base_q <= '0;
    end else begin
      s1_vld_q <= wr_acc;
      if (wr_acc) begin
        s1_idx_q  <= wr_idx;
        s1_data_q <= bus.wr_data;
        s1_base_q <= base_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (s1_vld_q) begin
      mem_q[s1_idx_q] <= sum_sat;
    end else if (accept) begin
      mem_q[cnt_q] <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_q <= 1'b0;
    end else if (drain_done_d) begin
      sat_q <= 1'b0;
    end else if (s1_vld_q && sum_ovf) begin
      sat_q <= 1'b1;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.out_valid  = (state_q == DRAIN);
  assign bus.out_entry  = cnt_q;
  assign bus.out_data   = (state_q == DRAIN) ? mem_q[cnt_q] : 8'sd0;
  assign bus.drain_done = drain_done_q;
  assign bus.sat_flag   = sat_q;
  assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_accum_bank.sv
// Randomized and directed bench for accum_bank against an array-based model
// of the saturating accumulator bank.
module tb_accum_bank;
  localparam int DEPTH     = 64;
  localparam int ROW_WIDTH = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;

  int         model [DEPTH];
  bit         sat_exp;
  logic [7:0] exp_q[$];

  accum_bank_if #(.DEPTH(DEPTH), .ROW_WIDTH(ROW_WIDTH)) bus ();

  accum_bank #(.DEPTH(DEPTH), .ROW_WIDTH(ROW_WIDTH)) dut (
    .clk         (clk),
    .reset_n     (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference model
  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 0;
  endtask

  task automatic model_wr(input int row, input int data, input int bw);
    int idx;
    int s;
    idx = (row >> bw) % DEPTH;
    s   = model[idx] + data;
    if (s > 127) begin
      s = 127;
      sat_exp = 1'b1;
    end else if (s < -128) begin
      s = -128;
      sat_exp = 1'b1;
    end
    model[idx] = s;
  endtask

  // drivers
  task automatic set_wr(input int row, input int data, input int bw);
    bus.wr_en    = 1'b1;
    bus.wr_row   = ROW_WIDTH'(row);
    bus.wr_data  = 8'(data);
    bus.bitwidth = 2'(bw);
  endtask

  task automatic wr_cycle(input int row, input int data, input int bw);
    set_wr(row, data, bw);
    model_wr(row, data, bw);
    tick();
  endtask

  task automatic idle(input int n);
    bus.wr_en = 1'b0;
    repeat (n) tick();
  endtask

  task automatic junk_wr();
    set_wr($urandom_range(0, 255), $urandom_range(0, 255) - 128, $urandom_range(0, 3));
  endtask

  task automatic apply_reset_checks(input string tag);
    check({tag, "_busy"},       int'(bus.busy),       0);
    check({tag, "_out_valid"},  int'(bus.out_valid),  0);
    check({tag, "_drain_done"}, int'(bus.drain_done), 0);
    check({tag, "_sat_flag"},   int'(bus.sat_flag),   0);
    check({tag, "_out_entry"},  int'(bus.out_entry),  0);
    check({tag, "_out_data"},   int'(bus.out_data),   0);
    check({tag, "_state"},      int'(dbg_state),      0);
  endtask

  // Drain with optional same-cycle write, junk writes while busy, a 5-cycle
  // stall at stall_e, random backpressure, and a reset abort at abort_e.
  task automatic do_drain(input bit with_wr, input bit junk, input int stall_e,
                          input int abort_e, input bit rand_ready);
    int n;
    int e;
    int stalls;
    int cyc;
    bit rdy;
    bus.drain_start = 1'b1;
    if (with_wr) wr_cycle($urandom_range(0, 255), $urandom_range(0, 16) - 8, $urandom_range(0, 3));
    else tick();
    bus.drain_start = 1'b0;
    bus.wr_en       = 1'b0;
    check("busy_after_start", int'(bus.busy), 1);

    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(model[i]));
    model_clear();

    n = 0;
    while (!bus.out_valid && n < 10) begin
      if (junk) junk_wr();
      tick();
      n++;
    end
    check("flush_len", n, 2);

    e = 0;
    stalls = 0;
    cyc = 0;
    while (e < DEPTH && cyc < 2000) begin
      check("out_valid", int'(bus.out_valid), 1);
      check("out_entry", int'(bus.out_entry), e);
      check("out_data", int'(bus.out_data), int'(exp_q[0]));
      check("drain_done_early", int'(bus.drain_done), 0);
      if (e == abort_e) begin
        rst_n = 1'b0;
        #1;
        apply_reset_checks("abort");
        model_clear();
        sat_exp = 1'b0;
        exp_q.delete();
        bus.out_ready = 1'b0;
        bus.wr_en     = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
          tick();
          check("abort_no_done", int'(bus.drain_done), 0);
          check("abort_idle", int'(bus.busy), 0);
        end
        return;
      end
      if (e == stall_e && stalls < 5) begin
        rdy = 1'b0;
        stalls++;
      end else if (rand_ready) begin
        rdy = ($urandom_range(0, 3) != 0);
      end else begin
        rdy = 1'b1;
      end
      bus.out_ready = rdy;
      if (junk) junk_wr();
      tick();
      cyc++;
      if (rdy) begin
        void'(exp_q.pop_front());
        e++;
      end
    end
    bus.out_ready = 1'b0;
    bus.wr_en     = 1'b0;
    check("drain_accepts", e, DEPTH);
    if (stall_e >= 0) check("stall_cycles", stalls, 5);
    check("drain_done", int'(bus.drain_done), 1);
    check("busy_end", int'(bus.busy), 0);
    check("out_valid_end", int'(bus.out_valid), 0);
    sat_exp = 1'b0;
    tick();
    check("drain_done_pulse", int'(bus.drain_done), 0);
    check("sat_after_drain", int'(bus.sat_flag), int'(sat_exp));
  endtask

  task automatic check_sat(input string tag);
    idle(2);
    check(tag, int'(bus.sat_flag), int'(sat_exp));
  endtask

  initial begin
    bus.bitwidth    = 2'd0;
    bus.wr_en       = 1'b0;
    bus.wr_row      = '0;
    bus.wr_data     = '0;
    bus.drain_start = 1'b0;
    bus.out_ready   = 1'b0;
    model_clear();
    sat_exp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    apply_reset_checks("reset");
    rst_n = 1'b1;
    idle(2);

    // +5, -3 to row 4, bitwidth 2 -> entry 1 = 2
    wr_cycle(4, 5, 2);
    wr_cycle(4, -3, 2);
    check_sat("sat_small");
    do_drain(1'b0, 1'b0, -1, -1, 1'b0);

    // four back-to-back +100 to row 0 -> saturate at 127
    for (int i = 0; i < 4; i++) wr_cycle(0, 100, 0);
    check_sat("sat_set");
    do_drain(1'b0, 1'b0, -1, -1, 1'b0);

    // alternating rows 8/9, then a drain stalled at entry 3
    for (int i = 0; i < 6; i++) wr_cycle(8 + (i % 2), 10, 0);
    idle(1);
    do_drain(1'b0, 1'b0, 3, -1, 1'b0);

    // writes while busy are dropped; second drain must be empty
    wr_cycle(5, 7, 0);
    wr_cycle(200, -20, 1);
    idle(1);
    do_drain(1'b0, 1'b1, -1, -1, 1'b1);
    do_drain(1'b0, 1'b0, -1, -1, 1'b0);

    // reset in the middle of a drain
    for (int i = 0; i < 20; i++) wr_cycle($urandom_range(0, 255), $urandom_range(0, 40) - 20, $urandom_range(0, 3));
    idle(1);
    do_drain(1'b0, 1'b0, -1, 10, 1'b0);
    do_drain(1'b0, 1'b0, -1, -1, 1'b0);

    // random traffic with a write landing in the drain_start cycle
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          wr_cycle($urandom_range(0, 255),
                   ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 255) - 128)
                                               : ($urandom_range(0, 16) - 8),
                   $urandom_range(0, 3));
        end else begin
          idle(1);
        end
      end
      check_sat("sat_random");
      do_drain(1'b1, 1'b0, -1, -1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/accum_bank.md
ACCUM_BANK -- requirements
Module: accum_bank

Interface
REQ-001 Parameter DEPTH, 64, number of 8-bit accumulator entries per bank (power of two).
REQ-002 Parameter ROW_WIDTH, 8, width of incoming row coordinate.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 bitwidth  input  2  operating mode; entry index = wr_row >> bitwidth, truncated to log2(DEPTH) bits.
REQ-006 wr_en  input  1  write strobe from the upstream crossbar bank port.
REQ-007 wr_row  input  ROW_WIDTH  row coordinate of the product.
REQ-008 wr_data  input  8  signed product, two's complement.
REQ-009 busy  output  1  high while draining; wr_en asserted while busy is ignored.
REQ-010 drain_start  input  1  single-cycle request to stream out and clear all entries.
REQ-011 out_valid  output  1  drain data valid.
REQ-012 out_ready  input  1  downstream accepts drain data.
REQ-013 out_entry  output  log2(DEPTH)  index of the entry presented.
REQ-014 out_data  output  8  signed accumulated value presented.
REQ-015 drain_done  output  1  one-cycle pulse after the last entry is accepted.
REQ-016 sat_flag  output  1  sticky; set on any saturation, cleared by drain_done or reset.

Function
REQ-017 Accumulation is a 2-stage read-modify-write: stage 1 registers entry index and data; stage 2 adds to the stored value and writes it back.
REQ-018 The addition is signed 8-bit with saturation: results above 127 clamp to 127, results below -128 clamp to -128, and sat_flag is set.
REQ-019 Back-to-back writes to the same entry forward the stage-2 result into stage 1; no update is lost and no stall occurs.
REQ-020 Throughput is one write per cycle; an update is visible in storage 2 cycles after wr_en.
REQ-021 The FSM has states IDLE, FLUSH and DRAIN; reset enters IDLE.
REQ-022 IDLE: drain_start moves the FSM to FLUSH and raises busy the next cycle.
REQ-023 FLUSH: the FSM lasts exactly 2 cycles so in-flight writes retire, then moves to DRAIN with entry counter 0.
REQ-024 DRAIN: out_valid=1 with out_entry=counter and out_data=storage[counter].
REQ-025 DRAIN handshake: on out_valid&&out_ready the entry is cleared to 0 and the counter increments.
REQ-026 DRAIN hold: while out_ready=0, out_entry and out_data are held stable.
REQ-027 Drain end: acceptance at counter DEPTH-1 pulses drain_done for one cycle, clears busy and out_valid, and returns the FSM to IDLE.
REQ-028 drain_start is ignored outside IDLE.
REQ-029 wr_en and drain_start in the same IDLE cycle: the write is accepted and included in the drain.
REQ-030 Entry index wraps modulo DEPTH.

Reset
REQ-031 Reset values:
- busy, out_valid, drain_done and sat_flag are 0.
- out_entry and out_data are 0.
- All entries and pipeline registers are cleared.
- The FSM is in IDLE.
REQ-032 Reset asserted mid-drain aborts the drain immediately; no drain_done is issued.

Verification
REQ-033 Writes of +5 and then -3 to row 4 with bitwidth=2, followed by a drain -> entry 1 reads 2; all other entries read 0.
REQ-034 Four consecutive cycles writing +100 to row 0 -> entry 0 reads 127 and sat_flag=1; sat_flag clears after drain_done.
REQ-035 Alternating consecutive writes of 10 to rows 8 and 9 with bitwidth=0, 3 of each -> entries 8 and 9 read 30 each, proving forwarding.
REQ-036 Drain with out_ready held low for 5 cycles at entry 3 -> out_entry=3 and out_data stay stable throughout; drain_done arrives exactly DEPTH accepts after the first.
REQ-037 wr_en asserted while busy=1 -> storage is unchanged, and a second drain returns all zeros.
REQ-038 reset_n pulsed low during DRAIN at entry 10 -> all outputs go to 0, the FSM returns to IDLE, and a subsequent drain reads all zeros.
